sp_ram_fifo_ctrl: RTL and testbench
===================================

Name: sp_ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the team's single-port RAM (sp_ram_model).
- Presents valid/ready push and pop interfaces.
- Arbitrates the single RAM port between writes and reads; each cycle the RAM does one read or one write.
- Hides the 1-cycle RAM read latency with a 3-entry output prefetch queue and an empty-FIFO bypass.
- Total capacity is DEPTH+3 entries.

Parameters:
- WIDTH, 8, data width; must equal the RAM WIDTH.
- DEPTH, 8, RAM entries, any integer >= 2 (power of 2 not required); must equal the RAM DEPTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  push request.
- in_ready  output  1  push accept (combinational from registered state only).
- in_data  input  WIDTH  push data.
- out_valid  output  1  head entry valid.
- out_ready  input  1  pop request.
- out_data  output  WIDTH  head entry data.
- ram_en  output  1  RAM enable.
- ram_wen  output  1  RAM write enable.
- ram_addr  output  $clog2(DEPTH)  RAM address.
- ram_din  output  WIDTH  RAM write data.
- ram_dout  input  WIDTH  RAM read data, valid the cycle after a read is issued.
- count  output  $clog2(DEPTH+4)  total entries held: ram_cnt + rd_pend + occ_out.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on rst.
- State:
  - wr_ptr, rd_ptr: 0..DEPTH-1; increment wraps DEPTH-1 -> 0 explicitly.
  - ram_cnt: 0..DEPTH.
  - rd_pend: 1 bit; means a read was issued last cycle.
  - Output queue: 3 entries, occupancy occ_out 0..3, in-order.
- Reset (async, any time, including mid-read):
  - Pointers, ram_cnt, rd_pend and occ_out clear to 0; any in-flight read is discarded.
  - Outputs in reset: out_valid=0, count=0, ram_en=0, ram_wen=0, in_ready=1. out_data is don't-care while out_valid=0.
  - RAM contents are not cleared and are never read back after reset.
- Per-cycle decisions, all from registered state:
  - rd_issue = (ram_cnt>0) && (occ_out + rd_pend < 3).
  - bypass_ok = (ram_cnt==0) && !rd_pend && (occ_out<3).
  - in_ready = bypass_ok || (!rd_issue && ram_cnt<DEPTH).
  - push = in_valid && in_ready; pop = out_valid && out_ready.
- Port arbitration: reads have priority. A RAM write occurs only when push && !bypass_ok; it never coincides with rd_issue.
- RAM drive:
  - ram_en = rd_issue || ram_write; ram_wen = ram_write.
  - ram_addr = rd_issue ? rd_ptr : wr_ptr; ram_din = in_data.
  - rd_ptr advances on rd_issue; wr_ptr advances on ram_write.
- Bypass: a push with bypass_ok writes in_data straight into the output queue tail. No RAM access; pointers are unchanged.
- Read return: when rd_pend=1, ram_dout is appended to the queue tail at that cycle's edge.
- Same-edge queue update: occ_out_next = occ_out + (bypass push) + rd_pend - pop. At most one append per cycle, guaranteed by the rd_pend/bypass exclusion.
- Ordering: strict FIFO. Bypass is allowed only when RAM and read pipe are empty.
- Latency:
  - Push into an empty FIFO: out_valid the next cycle.
  - RAM-resident entry: read issued in cycle T, visible at the head in T+2.
  - Continuous pop from a full FIFO runs one entry per cycle with no bubbles.
- Throughput: with simultaneous push and pop while ram_cnt>0, pushes stall during read cycles (port limit). No loss, no duplication.
- Full: count = DEPTH+3 gives in_ready=0.
- Empty: count = 0 gives out_valid=0. A pop without out_valid has no effect.
- out_data and out_valid are held stable while out_valid && !out_ready.

Test Plan:
- Reset: assert rst mid-stream, deassert -> out_valid=0, count=0, ram_en=0, in_ready=1 in the first cycle after reset.
- Bypass: empty FIFO, push 0xA5 with out_ready=1 -> out_valid=1, out_data=0xA5 the next cycle; ram_en never asserted; count returns to 0.
- Fill (DEPTH=8): out_ready=0, push 0..10 every cycle. Required response:
  - 0,1,2 bypass into the queue.
  - 3..10 are written to RAM addrs 0..7.
  - in_ready=0 at count=11; an 12th push is refused.
- Drain: from full, out_ready=1 held -> outputs 0..10 in order on 11 consecutive cycles, no gaps; count steps 11 down to 0.
- Concurrent and wrap:
  - Random in_valid/out_ready for 200 pushes of an incrementing pattern, using DEPTH=8 and DEPTH=5.
  - Scoreboard shows exact order and no loss.
  - ram_en && ram_wen is never asserted in the same cycle as a read; pointers wrap 7->0 and 4->0 respectively.
- Reset with read in flight: issue rst in the cycle after rd_issue -> captured data is dropped. The next push bypasses and appears at out_data one cycle later.

Source files
------------

// File: rtl/sp_ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sp_ram_fifo_ctrl
//
// Synchronous FIFO controller that drives a single-port RAM (sp_ram_model).
// The RAM port does at most one access per cycle, either a read or a write.
// Reads take priority over writes.
//
// The RAM has a 1-cycle read latency. A 3-entry output queue prefetches
// data ahead of the consumer to hide that latency. When the RAM and the
// read pipe are both empty, a push goes straight into the output queue
// (bypass). Total capacity is DEPTH+3 entries.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : push request
//   in_ready   : push accept (depends on registered state only)
//   in_data    : push data
//   out_valid  : head entry valid
//   out_ready  : pop request
//   out_data   : head entry data
//   ram_en     : RAM enable
//   ram_wen    : RAM write enable (ram_en && !ram_wen is a read)
//   ram_addr   : RAM address
//   ram_din    : RAM write data
//   ram_dout   : RAM read data, valid the cycle after a read is issued
//   count      : entries held = RAM entries + pending read + output queue
// ---------------------------------------------------------------------------
module sp_ram_fifo_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         ram_en,
    output logic                         ram_wen,
    output logic [$clog2(DEPTH)-1:0]     ram_addr,
    output logic [WIDTH-1:0]             ram_din,
    input  logic [WIDTH-1:0]             ram_dout,
    output logic [$clog2(DEPTH+4)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 4);

    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] RAM_FULL = CW'(DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [AW-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]    ram_cnt_q, ram_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic [1:0]       occ_q,     occ_d;
    logic [WIDTH-1:0] oq_q [3];
    logic [WIDTH-1:0] oq_d [3];

    // -----------------------------------------------------------------------
    // Per-cycle decisions, all derived from registered state
    // -----------------------------------------------------------------------
    logic [2:0]       rd_slots;
    logic             rd_issue;
    logic             bypass_ok;
    logic             push;
    logic             pop;
    logic             ram_write;
    logic             byp_push;
    logic             append;
    logic [WIDTH-1:0] app_data;
    logic [1:0]       tail;

    always_comb begin
        // A read may only be issued if the output queue has room for it
        // once the already-pending read has landed.
        rd_slots  = {1'b0, occ_q} + {2'b00, rd_pend_q};
        rd_issue  = (ram_cnt_q != '0) && (rd_slots < 3'd3);

        // Bypass keeps FIFO order only when nothing older sits in the RAM
        // or in the read pipe.
        bypass_ok = (ram_cnt_q == '0) && !rd_pend_q && (occ_q != 2'd3);

        in_ready  = bypass_ok || (!rd_issue && (ram_cnt_q < RAM_FULL));
        push      = in_valid && in_ready;
        pop       = (occ_q != 2'd0) && out_ready;

        ram_write = push && !bypass_ok;
        byp_push  = push && bypass_ok;

        // bypass_ok implies !rd_pend_q, so at most one source appends.
        append    = byp_push || rd_pend_q;
        app_data  = rd_pend_q ? ram_dout : in_data;

        // Tail slot after this cycle's pop has shifted the queue.
        tail      = occ_q - {1'b0, pop};
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        rd_pend_d = rd_issue;
        occ_d     = occ_q + {1'b0, append} - {1'b0, pop};
        for (int unsigned i = 0; i < 3; i++) begin
            oq_d[i] = oq_q[i];
        end

        // Pointers wrap explicitly so DEPTH need not be a power of two.
        if (ram_write) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
        end
        if (rd_issue) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
        end

        // ram_write and rd_issue are mutually exclusive.
        if (ram_write) begin
            ram_cnt_d = ram_cnt_q + CW'(1);
        end else if (rd_issue) begin
            ram_cnt_d = ram_cnt_q - CW'(1);
        end

        // Pop shifts the queue towards the head, then the append lands at
        // the post-shift tail so both can happen on the same edge.
        if (pop) begin
            oq_d[0] = oq_q[1];
            oq_d[1] = oq_q[2];
        end
        if (append) begin
            case (tail)
                2'd0:    oq_d[0] = app_data;
                2'd1:    oq_d[1] = app_data;
                default: oq_d[2] = app_data;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            occ_q     <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                oq_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            rd_pend_q <= rd_pend_d;
            occ_q     <= occ_d;
            for (int unsigned i = 0; i < 3; i++) begin
                oq_q[i] <= oq_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        out_valid = (occ_q != 2'd0);
        out_data  = oq_q[0];
        ram_en    = rd_issue || ram_write;
        ram_wen   = ram_write;
        ram_addr  = rd_issue ? rd_ptr_q : wr_ptr_q;
        ram_din   = in_data;
        count     = ram_cnt_q + CW'(rd_pend_q) + CW'(occ_q);
    end

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for sp_ram_fifo_ctrl. Two instances (DEPTH=8 and DEPTH=5) each drive
// their own behavioural single-port RAM with 1-cycle read latency.
// ---------------------------------------------------------------------------
module tb_sp_ram_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, ram_en8, ram_wen8;
    logic [7:0] in_data8, out_data8, ram_din8, ram_dout8;
    logic [2:0] ram_addr8;
    logic [3:0] count8;

    logic       in_valid5, in_ready5, out_valid5, out_ready5, ram_en5, ram_wen5;
    logic [7:0] in_data5, out_data5, ram_din5, ram_dout5;
    logic [2:0] ram_addr5;
    logic [3:0] count5;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb8[$];
    logic [7:0] sb5[$];

    sp_ram_fifo_ctrl #(.WIDTH(8), .DEPTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .ram_en(ram_en8), .ram_wen(ram_wen8), .ram_addr(ram_addr8),
        .ram_din(ram_din8), .ram_dout(ram_dout8), .count(count8)
    );

    sp_ram_fifo_ctrl #(.WIDTH(8), .DEPTH(5)) u_dut5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
        .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
        .ram_en(ram_en5), .ram_wen(ram_wen5), .ram_addr(ram_addr5),
        .ram_din(ram_din5), .ram_dout(ram_dout5), .count(count5)
    );

    // Single-port RAM models: one access per cycle, registered read data.
    logic [7:0] mem8 [8];
    logic [7:0] mem5 [5];

    always @(posedge clk) begin
        if (ram_en8) begin
            if (ram_wen8) mem8[ram_addr8] <= ram_din8;
            else          ram_dout8       <= mem8[ram_addr8];
        end
        if (ram_en5) begin
            if (ram_wen5) mem5[ram_addr5] <= ram_din5;
            else          ram_dout5       <= mem5[ram_addr5];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        @(negedge clk);
        out_ready8 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid8 = 1'b1;
            in_data8  = 8'h50 + 8'(k);
            @(negedge clk);
        end
        in_valid8 = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid8); end
        checks++; if (count8 !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count8); end
        checks++; if (ram_en8 !== 1'b0 || ram_wen8 !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got en=%b wen=%b want 0/0", ram_en8, ram_wen8); end
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready8); end
        checks++; if (count5 !== 4'd0 || in_ready5 !== 1'b1) begin errors++; $display("FAIL reset_dut5: got count=%0d in_ready=%b want 0/1", count5, in_ready5); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb8.delete();
        sb5.delete();
        #1;
        checks++; if (out_valid8 !== 1'b0 || count8 !== 4'd0) begin errors++; $display("FAIL post_reset_state: got valid=%b count=%0d want 0/0", out_valid8, count8); end
        checks++; if (ram_en8 !== 1'b0 || in_ready8 !== 1'b1) begin errors++; $display("FAIL post_reset_ports: got ram_en=%b in_ready=%b want 0/1", ram_en8, in_ready8); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        in_valid8  = 1'b1;
        in_data8   = 8'hA5;
        out_ready8 = 1'b1;
        #1;
        checks++; if (ram_en8 !== 1'b0) begin errors++; $display("FAIL bypass_push_ram_en: got %b want 0", ram_en8); end
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL bypass_in_ready: got %b want 1", in_ready8); end
        if (in_valid8 && in_ready8) sb8.push_back(in_data8);
        @(negedge clk);
        in_valid8 = 1'b0;
        #1;
        checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL bypass_out_valid: got %b want 1", out_valid8); end
        checks++;
        if (sb8.size() == 0) begin errors++; $display("FAIL bypass_data: scoreboard empty, got %h", out_data8); end
        else begin
            if (out_data8 !== sb8[0]) begin errors++; $display("FAIL bypass_data: got %h want %h", out_data8, sb8[0]); end
            if (out_valid8 && out_ready8) void'(sb8.pop_front());
        end
        checks++; if (ram_en8 !== 1'b0 || count8 !== 4'd1) begin errors++; $display("FAIL bypass_head_cycle: got ram_en=%b count=%0d want 0/1", ram_en8, count8); end
        @(negedge clk);
        #1;
        checks++; if (count8 !== 4'd0 || out_valid8 !== 1'b0) begin errors++; $display("FAIL bypass_drained: got count=%0d valid=%b want 0/0", count8, out_valid8); end
    endtask

    task automatic test_fill();
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            in_valid8  = 1'b1;
            in_data8   = 8'(k);
            out_ready8 = 1'b0;
            #1;
            checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d]: got %b want 1", k, in_ready8); end
            checks++; if (ram_en8 !== (k >= 3) || ram_wen8 !== (k >= 3)) begin errors++; $display("FAIL fill_ram_write[%0d]: got en=%b wen=%b want %0d", k, ram_en8, ram_wen8, k >= 3); end
            if (k >= 3) begin
                checks++; if (ram_addr8 !== 3'(k - 3) || ram_din8 !== 8'(k)) begin errors++; $display("FAIL fill_ram_addr[%0d]: got addr=%0d din=%0d want %0d/%0d", k, ram_addr8, ram_din8, k - 3, k); end
            end
            if (in_valid8 && in_ready8) sb8.push_back(in_data8);
        end
        @(negedge clk);
        in_valid8 = 1'b1;
        in_data8  = 8'd11;
        #1;
        checks++; if (count8 !== 4'd11 || in_ready8 !== 1'b0) begin errors++; $display("FAIL fill_full: got count=%0d in_ready=%b want 11/0", count8, in_ready8); end
        checks++; if (ram_en8 !== 1'b0) begin errors++; $display("FAIL fill_full_ram_en: got %b want 0", ram_en8); end
        @(negedge clk);
        #1;
        checks++; if (count8 !== 4'd11 || in_ready8 !== 1'b0) begin errors++; $display("FAIL fill_refused: got count=%0d in_ready=%b want 11/0", count8, in_ready8); end
        checks++; if (out_valid8 !== 1'b1 || out_data8 !== 8'd0) begin errors++; $display("FAIL fill_head_hold: got valid=%b data=%0d want 1/0", out_valid8, out_data8); end
    endtask

    task automatic test_drain();
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            in_valid8  = 1'b0;
            out_ready8 = 1'b1;
            #1;
            checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL drain_gap[%0d]: got out_valid %b want 1", k, out_valid8); end
            checks++; if (int'(count8) != 11 - k) begin errors++; $display("FAIL drain_count[%0d]: got %0d want %0d", k, count8, 11 - k); end
            checks++;
            if (sb8.size() == 0) begin errors++; $display("FAIL drain_data[%0d]: scoreboard empty, got %0d", k, out_data8); end
            else begin
                if (out_data8 !== sb8[0]) begin errors++; $display("FAIL drain_data[%0d]: got %0d want %0d", k, out_data8, sb8[0]); end
                if (out_valid8 && out_ready8) void'(sb8.pop_front());
            end
        end
        @(negedge clk);
        #1;
        checks++; if (out_valid8 !== 1'b0 || count8 !== 4'd0) begin errors++; $display("FAIL drain_empty: got valid=%b count=%0d want 0/0", out_valid8, count8); end
    endtask

    task automatic test_concurrent();
        int n8 = 0, n5 = 0, wa8 = 0, ra8 = 0, wa5 = 0, ra5 = 0;
        int cyc = 0;
        logic wrap8 = 1'b0, wrap5 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb8.delete();
        sb5.delete();
        while (!(n8 == 200 && n5 == 200 && sb8.size() == 0 && sb5.size() == 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_valid8  = (n8 < 200) && ($urandom_range(0, 9) < 7);
            in_data8   = 8'(n8);
            out_ready8 = (n8 == 200) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid5  = (n5 < 200) && ($urandom_range(0, 9) < 7);
            in_data5   = 8'(n5);
            out_ready5 = (n5 == 200) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            // DEPTH=8 instance
            checks++; if (int'(count8) != sb8.size()) begin errors++; $display("FAIL conc8_count: got %0d want %0d", count8, sb8.size()); end
            if (out_valid8 && out_ready8) begin
                checks++;
                if (sb8.size() == 0) begin errors++; $display("FAIL conc8_extra: got %0d with empty scoreboard", out_data8); end
                else begin
                    if (out_data8 !== sb8[0]) begin errors++; $display("FAIL conc8_order: got %0d want %0d", out_data8, sb8[0]); end
                    void'(sb8.pop_front());
                end
            end
            if (ram_en8 && ram_wen8) begin
                checks++; if (ram_addr8 !== 3'(wa8) || ram_din8 !== in_data8 || !(in_valid8 && in_ready8)) begin errors++; $display("FAIL conc8_write: got addr=%0d din=%0d push=%b want addr=%0d din=%0d push=1", ram_addr8, ram_din8, in_valid8 && in_ready8, wa8, in_data8); end
                wa8 = (wa8 == 7) ? 0 : wa8 + 1;
                if (wa8 == 0) wrap8 = 1'b1;
            end else if (ram_en8) begin
                checks++; if (ram_addr8 !== 3'(ra8)) begin errors++; $display("FAIL conc8_read_addr: got %0d want %0d", ram_addr8, ra8); end
                ra8 = (ra8 == 7) ? 0 : ra8 + 1;
            end
            if (in_valid8 && in_ready8) begin sb8.push_back(in_data8); n8++; end
            // DEPTH=5 instance
            checks++; if (int'(count5) != sb5.size()) begin errors++; $display("FAIL conc5_count: got %0d want %0d", count5, sb5.size()); end
            if (out_valid5 && out_ready5) begin
                checks++;
                if (sb5.size() == 0) begin errors++; $display("FAIL conc5_extra: got %0d with empty scoreboard", out_data5); end
                else begin
                    if (out_data5 !== sb5[0]) begin errors++; $display("FAIL conc5_order: got %0d want %0d", out_data5, sb5[0]); end
                    void'(sb5.pop_front());
                end
            end
            if (ram_en5 && ram_wen5) begin
                checks++; if (ram_addr5 !== 3'(wa5) || ram_din5 !== in_data5 || !(in_valid5 && in_ready5)) begin errors++; $display("FAIL conc5_write: got addr=%0d din=%0d push=%b want addr=%0d din=%0d push=1", ram_addr5, ram_din5, in_valid5 && in_ready5, wa5, in_data5); end
                wa5 = (wa5 == 4) ? 0 : wa5 + 1;
                if (wa5 == 0) wrap5 = 1'b1;
            end else if (ram_en5) begin
                checks++; if (ram_addr5 !== 3'(ra5)) begin errors++; $display("FAIL conc5_read_addr: got %0d want %0d", ram_addr5, ra5); end
                ra5 = (ra5 == 4) ? 0 : ra5 + 1;
            end
            if (in_valid5 && in_ready5) begin sb5.push_back(in_data5); n5++; end
        end
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        in_valid5 = 1'b0; out_ready5 = 1'b0;
        checks++; if (cyc >= 20000) begin errors++; $display("FAIL conc_timeout: pushed %0d/%0d left %0d/%0d", n8, n5, sb8.size(), sb5.size()); end
        checks++; if (wrap8 !== 1'b1 || wrap5 !== 1'b1) begin errors++; $display("FAIL conc_wrap: got wrap8=%b wrap5=%b want 1/1", wrap8, wrap5); end
    endtask

    task automatic test_reset_inflight();
        logic found = 1'b0;
        @(negedge clk);
        out_ready8 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid8 = 1'b1;
            in_data8  = 8'h60 + 8'(k);
            @(negedge clk);
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (ram_en8 && !ram_wen8) found = 1'b1;
            @(negedge clk);
        end
        // Now in the cycle after the read was issued: read data is in flight.
        out_ready8 = 1'b0;
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL inflight_no_read: got found=%b want 1", found); end
        #1 rst = 1'b1;
        #1;
        checks++; if (count8 !== 4'd0 || out_valid8 !== 1'b0) begin errors++; $display("FAIL inflight_reset: got count=%0d valid=%b want 0/0", count8, out_valid8); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb8.delete();
        #1;
        checks++; if (count8 !== 4'd0 || out_valid8 !== 1'b0) begin errors++; $display("FAIL inflight_dropped: got count=%0d valid=%b want 0/0", count8, out_valid8); end
        @(negedge clk);
        in_valid8 = 1'b1;
        in_data8  = 8'h3C;
        #1;
        checks++; if (ram_en8 !== 1'b0 || in_ready8 !== 1'b1) begin errors++; $display("FAIL inflight_bypass_push: got ram_en=%b in_ready=%b want 0/1", ram_en8, in_ready8); end
        if (in_valid8 && in_ready8) sb8.push_back(in_data8);
        @(negedge clk);
        in_valid8 = 1'b0;
        #1;
        checks++;
        if (sb8.size() == 0) begin errors++; $display("FAIL inflight_bypass_data: scoreboard empty, got %h", out_data8); end
        else if (out_valid8 !== 1'b1 || out_data8 !== sb8[0] || count8 !== 4'd1) begin
            errors++; $display("FAIL inflight_bypass_data: got valid=%b data=%h count=%0d want 1/%h/1", out_valid8, out_data8, count8, sb8[0]);
        end
        @(negedge clk);
        out_ready8 = 1'b1;
        if (sb8.size() != 0) void'(sb8.pop_front());
        @(negedge clk);
        out_ready8 = 1'b0;
        #1;
        checks++; if (count8 !== 4'd0 || out_valid8 !== 1'b0) begin errors++; $display("FAIL inflight_final: got count=%0d valid=%b want 0/0", count8, out_valid8); end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid8  = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
        in_valid5  = 1'b0; in_data5 = '0; out_ready5 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_bypass();
        test_fill();
        test_drain();
        test_concurrent();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
